// File: rtl/page_rank_sample_pkg.sv
// Shared definitions for the PageRank sample engine: FSM states,
// INIT/BASE constant derivation and the Q0.WIDTH multiply-truncate helper.
package page_rank_sample_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } pr_state_e;

    // Starting rank of every node: an even share of 1.0 in Q0.width.
    function automatic longint unsigned init_rank(input int unsigned width,
                                                  input int unsigned n);
        return (64'd1 << width) / 64'(n);
    endfunction

    // Teleport term (1 - d)/N, truncated.
    function automatic longint unsigned base_rank(input int unsigned width,
                                                  input int unsigned n,
                                                  input longint unsigned damp);
        return ((64'd1 << width) - damp) / 64'(n);
    endfunction

    // Product of an integer-scaled operand with a Q0.width fraction,
    // truncated back to the first operand's scale. Operand widths must
    // sum to at most 64 bits.
    function automatic logic [63:0] mul_trunc(input logic [63:0] a,
                                              input logic [63:0] b,
                                              input int unsigned width);
        return (a * b) >> width;
    endfunction

endpackage

// File: rtl/page_rank_sample_pr_mac.sv
// Single fixed-point multiply: a (AW bits) times a Q0.WIDTH fraction b,
// result truncated back to AW bits.
module pr_mac
    import page_rank_sample_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = 16
) (
    input  logic [AW-1:0]    a,
    input  logic [WIDTH-1:0] b,
    output logic [AW-1:0]    p
);

    assign p = AW'(mul_trunc(64'(a), 64'(b), unsigned'(WIDTH)));

endmodule

// File: rtl/page_rank_sample.sv
// Fixed-point damped PageRank over a static N-node graph. One source node
// is scattered per ACCUM cycle; all ranks are refreshed in one UPDATE cycle.
// After ITERS iterations the engine freezes until reset.
module page_rank_sample
    import page_rank_sample_pkg::*;
#(
    parameter int               N     = 16,
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] DAMP  = WIDTH'(16'hD99A),
    parameter int               ITERS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*N-1:0]       adj,
    input  logic [N*WIDTH-1:0]   nodeWeight,
    output logic [WIDTH-1:0]     node0Val
);

    localparam int LOGN = $clog2(N);
    // Accumulator width: N contributions of at most 2^WIDTH-1 never overflow.
    localparam int AW   = WIDTH + LOGN;
    localparam int IW   = $clog2(ITERS + 1);

    localparam logic [WIDTH-1:0] INIT      = WIDTH'(init_rank(WIDTH, N));
    localparam logic [WIDTH-1:0] BASE      = WIDTH'(base_rank(WIDTH, N, 64'(DAMP)));
    localparam logic [LOGN-1:0]  LAST_J    = LOGN'(N - 1);
    localparam logic [IW-1:0]    LAST_ITER = IW'(ITERS - 1);

    pr_state_e         state_reg, state_next;
    logic [LOGN-1:0]   j_reg, j_next;
    logic [IW-1:0]     iter_reg, iter_next;
    logic              accum_en;
    logic              update_en;

    logic [WIDTH-1:0]  rank_arr   [N];
    logic [WIDTH-1:0]  weight_arr [N];
    logic [WIDTH-1:0]  cur_rank;
    logic [WIDTH-1:0]  cur_weight;
    logic [WIDTH-1:0]  contrib;

    // Control state: phase, current source node and completed iterations.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_ACCUM;
            j_reg     <= '0;
            iter_reg  <= '0;
        end else begin
            state_reg <= state_next;
            j_reg     <= j_next;
            iter_reg  <= iter_next;
        end
    end

    // Next-state logic and datapath enables.
    always_comb begin
        state_next = state_reg;
        j_next     = j_reg;
        iter_next  = iter_reg;
        accum_en   = 1'b0;
        update_en  = 1'b0;
        case (state_reg)
            ST_ACCUM: begin
                accum_en = 1'b1;
                j_next   = j_reg + 1'b1;
                if (j_reg == LAST_J) begin
                    state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                update_en  = 1'b1;
                j_next     = '0;
                iter_next  = iter_reg + 1'b1;
                state_next = (iter_reg == LAST_ITER) ? ST_DONE : ST_ACCUM;
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_ACCUM;
            end
        endcase
    end

    // Contribution of the current source: rank[j] scaled by its outgoing share.
    assign cur_rank   = rank_arr[j_reg];
    assign cur_weight = weight_arr[j_reg];

    pr_mac #(
        .WIDTH (WIDTH),
        .AW    (WIDTH)
    ) u_contrib (
        .a (cur_rank),
        .b (cur_weight),
        .p (contrib)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_node
            logic [N-1:0]     row_adj;
            logic [AW-1:0]    acc_reg;
            logic [AW-1:0]    damped;
            logic [AW:0]      sum;
            logic [WIDTH-1:0] rank_reg;
            logic [WIDTH-1:0] rank_next;

            assign row_adj        = adj[gi*N +: N];
            assign weight_arr[gi] = nodeWeight[gi*WIDTH +: WIDTH];
            assign rank_arr[gi]   = rank_reg;

            pr_mac #(
                .WIDTH (WIDTH),
                .AW    (AW)
            ) u_damp (
                .a (acc_reg),
                .b (DAMP),
                .p (damped)
            );

            // Teleport term plus damped in-flow, clamped instead of wrapping.
            assign sum       = {1'b0, damped} + (AW+1)'(BASE);
            assign rank_next = (|sum[AW:WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

            // Gather in-flow while scanning sources; cleared for the next iteration.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc_reg <= '0;
                end else if (accum_en && row_adj[j_reg]) begin
                    acc_reg <= acc_reg + AW'(contrib);
                end else if (update_en) begin
                    acc_reg <= '0;
                end
            end

            // Rank is only rewritten at the end of each iteration.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rank_reg <= INIT;
                end else if (update_en) begin
                    rank_reg <= rank_next;
                end
            end
        end
    endgenerate

    assign node0Val = rank_arr[0];

endmodule

// File: tb/tb_page_rank_sample.sv
// Directed bench for page_rank_sample: reset values, iteration latency,
// simple graphs, mid-run reset, halt after ITERS and saturation.
module tb_page_rank_sample;

    localparam int N     = 16;
    localparam int WIDTH = 16;

    logic                 clk;
    logic                 reset;
    logic [N*N-1:0]       adj;
    logic [N*WIDTH-1:0]   node_weight;
    logic [WIDTH-1:0]     val;
    logic [WIDTH-1:0]     val_sat;

    int n_checks;
    int n_fail;

    page_rank_sample #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .adj        (adj),
        .nodeWeight (node_weight),
        .node0Val   (val)
    );

    // Same engine with d = 0xFFFF (BASE = 0).
    page_rank_sample #(
        .N     (N),
        .WIDTH (WIDTH),
        .DAMP  (16'hFFFF)
    ) u_sat (
        .clk        (clk),
        .reset      (reset),
        .adj        (adj),
        .nodeWeight (node_weight),
        .node0Val   (val_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        $display("check %s: observed 0x%h expected 0x%h", tag, obs, exp);
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Assert reset, then release on a falling edge so the next rising
    // edge is cycle 1 after release.
    task automatic restart();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Advance n rising edges and sample 1 ns later.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        adj         = '0;
        node_weight = '0;

        // Reset held: ranks at INIT.
        cycles(3);
        check("reset_hold", val, 16'h1000);
        check("reset_hold_sat", val_sat, 16'h1000);

        // Empty graph: rank becomes BASE on cycle 17 and stays.
        restart();
        cycles(16);
        check("empty_c16", val, 16'h1000);
        cycles(1);
        check("empty_c17", val, 16'h0266);
        cycles(17);
        check("empty_c34", val, 16'h0266);
        cycles(66);
        check("empty_c100", val, 16'h0266);

        // Single edge 1->0 with full share.
        adj         = '0;
        adj[1]      = 1'b1;
        node_weight = {N{16'hFFFF}};
        restart();
        cycles(17);
        check("edge_it1", val, 16'h0FFE);
        cycles(17);
        check("edge_it2", val, 16'h046F);
        cycles(17);
        check("edge_it3", val, 16'h046F);

        // Mid-run reset at cycle 8 of iteration 2, then a fresh trajectory.
        restart();
        cycles(25);
        reset = 1'b0;
        #1;
        check("midrst_async", val, 16'h1000);
        check("midrst_async_sat", val_sat, 16'h1000);
        @(negedge clk);
        reset = 1'b1;
        cycles(17);
        check("midrst_it1", val, 16'h0FFE);
        cycles(17);
        check("midrst_it2", val, 16'h046F);

        // Fan-in: nodes 1..15 all feed node 0.
        adj         = '0;
        adj[15:1]   = '1;
        restart();
        cycles(17);
        check("fanin_it1", val, 16'hCE59);

        // Halt: node-0 self-loop; with d = 0xFFFF the rank drops by 2 per
        // iteration, so any extra iteration would be visible.
        adj         = '0;
        adj[0]      = 1'b1;
        restart();
        cycles(17);
        check("halt_it1", val, 16'h0FFE);
        check("halt_it1_sat", val_sat, 16'h0FFE);
        cycles(17);
        check("halt_it2", val, 16'h0FFD);
        check("halt_it2_sat", val_sat, 16'h0FFC);
        cycles(221);
        check("halt_it15_sat", val_sat, 16'h0FE2);
        cycles(17);
        check("halt_it16_sat", val_sat, 16'h0FE0);
        cycles(28);
        check("halt_c300_sat", val_sat, 16'h0FE0);

        // Saturation: complete graph with self-loops, full shares.
        adj = '1;
        restart();
        cycles(17);
        check("sat_it1", val, 16'hDBF2);
        check("sat_it1_sat", val_sat, 16'hFFEF);
        cycles(17);
        check("sat_it2", val, 16'hFFFF);
        check("sat_it2_sat", val_sat, 16'hFFFF);
        cycles(17 * 14);
        check("sat_it16", val, 16'hFFFF);
        check("sat_it16_sat", val_sat, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
